muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operation request / result bundle for the iterative multiply-divide unit.
// The requester drives operands and controls; the unit returns status and results.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] pa;
  logic [WIDTH-1:0] pb;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, pa, pb, flush,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, pa, pb, flush,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply (shift-add) and divide (restoring) unit
// with a one-cycle done pulse; signed ops run on magnitudes and fix signs at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     CLK,
  input  logic     nRST,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_dz_accept;
  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;
  logic [WIDTH-1:0] w_fhi;
  logic [WIDTH-1:0] w_flo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  assign w_accept    = ((r_state == IDLE) || (r_state == DONE)) && bus.start && !bus.flush;
  assign w_dz_accept = w_accept && bus.op[1] && (bus.pb == '0);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; flush overrides everything but reset
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            w_next = w_dz_accept ? DONE : BUSY;
          end else begin
            w_next = IDLE;
          end
        end
        BUSY: begin
          if (w_last) begin
            w_next = DONE;
          end else begin
            w_next = BUSY;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // One iteration step plus the sign-corrected final result
  always_comb begin
    w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_b};
    w_nhi   = '0;
    w_nlo   = '0;
    w_fhi   = '0;
    w_flo   = '0;
    if (r_is_div) begin
      if (!w_trial[WIDTH]) begin
        w_nhi = w_trial[WIDTH-1:0];
        w_nlo = {r_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_nhi = w_shift[WIDTH-1:0];
        w_nlo = {r_acc_lo[WIDTH-2:0], 1'b0};
      end
      w_fhi = r_neg_r ? -w_nhi : w_nhi;
      w_flo = r_neg_q ? -w_nlo : w_nlo;
    end else begin
      {w_nhi, w_nlo} = {w_sum, r_acc_lo[WIDTH-1:1]};
      if (r_neg_q) begin
        {w_fhi, w_flo} = -{w_nhi, w_nlo};
      end else begin
        {w_fhi, w_flo} = {w_nhi, w_nlo};
      end
    end
  end

  // Operand latch, iteration registers and result/status outputs
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_next == BUSY);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_cnt    <= '0;
        r_is_div <= bus.op[1];
        r_neg_q  <= bus.op[0] && (bus.pa[WIDTH-1] ^ bus.pb[WIDTH-1]);
        r_neg_r  <= bus.op[0] && bus.op[1] && bus.pa[WIDTH-1];
        r_acc_hi <= '0;
        r_acc_lo <= mag(bus.pa, bus.op[0]);
        r_b      <= mag(bus.pb, bus.op[0]);
      end else if (r_state == BUSY) begin
        r_cnt    <= r_cnt + CW'(1);
        r_acc_hi <= w_nhi;
        r_acc_lo <= w_nlo;
      end else begin
        r_cnt <= r_cnt;
      end
      // Results only move on entry to DONE
      if (w_dz_accept) begin
        r_hi <= bus.pa;
        r_lo <= '1;
        r_dz <= 1'b1;
      end else if ((r_state == BUSY) && w_last && !bus.flush) begin
        r_hi <= w_fhi;
        r_lo <= w_flo;
        r_dz <= 1'b0;
      end else begin
        r_hi <= r_hi;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.div_zero = r_dz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic nRST;
  muldiv_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 idle, 1 iterating, 2 result cycle
  int          m_phase = 0;
  int          m_left  = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_hi, m_lo;
  logic        m_dz;
  logic [64:0] m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {div_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] up;
    longint      sp;
    int          sa, sb;
    case (op)
      2'd0: begin
        up = {32'd0, a} * {32'd0, b};
        return {1'b0, up};
      end
      2'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, sp[63:0]};
      end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  always @(posedge CLK) begin
    logic [64:0] r;
    if (!nRST) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_left  = 0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      m_dz    = 1'b0;
    end else if (bus.flush) begin
      m_phase = 0;
    end else if (m_phase != 1 && bus.start) begin
      r = ref_op(bus.op, bus.pa, bus.pb);
      if (r[64]) begin
        m_phase = 2;
        {m_dz, m_hi, m_lo} = r;
      end else begin
        m_phase = 1;
        m_left  = W;
        m_pend  = r;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = 2;
        {m_dz, m_hi, m_lo} = m_pend;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("busy", {31'd0, bus.busy}, {31'd0, m_phase == 1});
      check("done", {31'd0, bus.done}, {31'd0, m_phase == 2});
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
      check("div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Present one request for a single cycle, then scramble the idle inputs
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.pa    = a;
    bus.pb    = b;
    step();
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.pa    = $urandom;
    bus.pb    = $urandom;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (bus.done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'd0;
    bus.pa    = 32'd0;
    bus.pb    = 32'd0;
    nRST      = 1'b0;
    repeat (2) step();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    nRST = 1'b1;
    step();

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_k1", {31'd0, bus.busy}, 32'd1);
    wait_done(1, n);
    check("multu_latency", n, 32'd33);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    issue(2'd1, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, n);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFF1);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, n);
    check("div_b2b_latency", n, 32'd33);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    step();
    issue(2'd2, 32'h64, 32'd0);
    check("dz_busy", {31'd0, bus.busy}, 32'd0);
    wait_done(1, n);
    check("dz_latency", n, 32'd1);
    check("dz_flag", {31'd0, bus.div_zero}, 32'd1);
    check("dz_hi", bus.hi, 32'h0000_0064);
    check("dz_lo", bus.lo, 32'hFFFF_FFFF);

    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, n);
    check("ovf_lo", bus.lo, 32'h8000_0000);
    check("ovf_hi", bus.hi, 32'h0000_0000);
    check("ovf_dz", {31'd0, bus.div_zero}, 32'd0);

    step();
    issue(2'd0, 32'd7, 32'd6);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.op    = 2'($urandom);
      bus.pa    = $urandom;
      bus.pb    = 32'd0;
      step();
    end
    bus.start = 1'b0;
    wait_done(6, n);
    check("ignore_latency", n, 32'd33);
    check("ignore_lo", bus.lo, 32'd42);
    check("ignore_hi", bus.hi, 32'd0);

    step();
    issue(2'd0, 32'd3, 32'd3);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) n++;
      step();
    end
    check("flush_no_done", n, 32'd0);
    check("flush_lo", bus.lo, 32'd42);
    check("flush_hi", bus.hi, 32'd0);

    issue(2'd2, 32'd1000, 32'd3);
    repeat (14) step();
    nRST = 1'b0;
    step();
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_hi", bus.hi, 32'd0);
    check("mrst_lo", bus.lo, 32'd0);
    nRST = 1'b1;
    issue(2'd2, 32'd100, 32'd7);
    wait_done(1, n);
    check("mrst_latency", n, 32'd33);
    check("mrst_lo_q", bus.lo, 32'd14);
    check("mrst_hi_r", bus.hi, 32'd2);

    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.pa    = pick();
      bus.pb    = pick();
      bus.flush = ($urandom_range(0, 79) == 0);
      step();
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
